note_player_mc: RTL and testbench

//  N-channel successor of the single-voice note player. Each channel latches a note (pitch, duration,

---
 rtl/note_player_mc_if.sv | 11 +
 rtl/note_player_mc.sv | 216 +++++++++++++++++++++
 tb/tb_note_player_mc.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_player_mc_if.sv
// note_player_mc_if: shared synchronous ROM port of the note player.
// The master drives the address and the slave returns data one cycle later.
interface note_player_mc_if #(
    parameter int ROM_AW = 8
) ();
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/note_player_mc.sv
// note_player_mc: N-voice note player time-multiplexed over one shared ROM.
// Optional: define NOTE_PLAYER_MC_MUTE_EN to add the per-channel i_mute port.
module note_player_mc #(
    parameter int NUM_CH     = 3,
    parameter int ROM_AW     = 8,
    parameter int PITCH_BASE = 0,
    parameter int ENV_BASE   = 128,
    parameter int ENV_LEN    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_frame_stb,
    input  logic [NUM_CH-1:0]    i_load,
    input  logic [6*NUM_CH-1:0]  i_pitch,
    input  logic [5*NUM_CH-1:0]  i_duration,
    input  logic [4*NUM_CH-1:0]  i_instrument,
`ifdef NOTE_PLAYER_MC_MUTE_EN
    input  logic [NUM_CH-1:0]    i_mute,
`endif
    note_player_mc_if.master     rom,
    output logic [32*NUM_CH-1:0] o_phase_delta,
    output logic [9*NUM_CH-1:0]  o_envelope,
    output logic [NUM_CH-1:0]    o_done,
    output logic                 o_busy,
    output logic                 o_overrun
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SW = (ENV_LEN > 1) ? $clog2(ENV_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE, LD_HI, LD_LO, LD_END, FR_ADDR, FR_CAP
    } state_t;

    // shadow registers written by the load pulses
    logic [5:0]        r_sh_pitch [NUM_CH];
    logic [4:0]        r_sh_dur   [NUM_CH];
    logic [3:0]        r_sh_instr [NUM_CH];
    logic [NUM_CH-1:0] r_ld_pend;
    logic              r_fr_pend;

    // sequencer state
    state_t            r_state;
    logic [CW-1:0]     r_ch;
    logic [ROM_AW-1:0] r_addr;
    logic [15:0]       r_hi;
    logic [4:0]        r_cur_dur;
    logic [3:0]        r_cur_instr;

    // per-channel voice state
    logic [NUM_CH-1:0] r_act;
    logic [4:0]        r_dur   [NUM_CH];
    logic [SW-1:0]     r_step  [NUM_CH];
    logic [3:0]        r_instr [NUM_CH];

    logic              w_ld_any;
    logic [CW-1:0]     w_ld_ch;
    logic [CW-1:0]     w_nx_ch;
    logic              w_last;
    logic              w_go_ld;
    logic              w_fr_clr;
    logic [NUM_CH-1:0] w_ld_clr;
    logic [NUM_CH-1:0] w_mute;

`ifdef NOTE_PLAYER_MC_MUTE_EN
    assign w_mute = i_mute;
`else
    assign w_mute = '0;
`endif

    function automatic logic [ROM_AW-1:0] env_addr(
        input logic [3:0]    instr,
        input logic [SW-1:0] step
    );
        logic [31:0] a;
        a = 32'(ENV_BASE) + 32'(instr) * 32'(ENV_LEN) + 32'(step);
        return a[ROM_AW-1:0];
    endfunction

    function automatic logic [ROM_AW-1:0] pitch_addr(input logic [5:0] p);
        logic [31:0] a;
        a = 32'(PITCH_BASE) + 32'(p) * 32'd2;
        return a[ROM_AW-1:0];
    endfunction

    assign rom.rom_addr = r_addr;
    assign o_busy       = (r_state != IDLE);
    assign w_nx_ch      = r_ch + CW'(1);
    assign w_last       = (r_ch == CW'(NUM_CH - 1));
    assign w_fr_clr     = (r_state == FR_CAP) && w_last;

    // pick the lowest pending load; a load may start from IDLE or straight
    // from the end of a frame pass so the sequencer stays busy across both
    always_comb begin
        w_ld_any = |r_ld_pend;
        w_ld_ch  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (r_ld_pend[c]) w_ld_ch = CW'(c);
        end
        w_go_ld  = w_ld_any && ((r_state == IDLE) || w_fr_clr);
        w_ld_clr = w_go_ld ? (NUM_CH'(1) << w_ld_ch) : '0;
    end

    // shadow capture: the last load before service wins
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sh_pitch[c] <= '0;
                r_sh_dur[c]   <= '0;
                r_sh_instr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (i_load[c]) begin
                    r_sh_pitch[c] <= i_pitch[6*c +: 6];
                    r_sh_dur[c]   <= i_duration[5*c +: 5];
                    r_sh_instr[c] <= i_instrument[4*c +: 4];
                end
            end
        end
    end

    // pending flags; a new load re-arms even while its old one is served
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_pend <= '0;
            r_fr_pend <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            r_ld_pend <= (r_ld_pend & ~w_ld_clr) | i_load;
            r_fr_pend <= i_frame_stb | (r_fr_pend & ~w_fr_clr);
            o_overrun <= i_frame_stb & r_fr_pend & ~w_fr_clr;
        end
    end

    // sequencer: pitch loads and per-frame envelope pass over the shared ROM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_ch          <= '0;
            r_addr        <= '0;
            r_hi          <= '0;
            r_cur_dur     <= '0;
            r_cur_instr   <= '0;
            r_act         <= '0;
            o_phase_delta <= '0;
            o_envelope    <= '0;
            o_done        <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_dur[c]   <= '0;
                r_step[c]  <= '0;
                r_instr[c] <= '0;
            end
        end else begin
            o_done <= '0;
            unique case (r_state)
                IDLE: begin
                    if (r_fr_pend) begin
                        r_state <= FR_ADDR;
                        r_ch    <= '0;
                        r_addr  <= env_addr(r_instr[0], r_step[0]);
                    end
                end
                LD_HI: begin
                    r_addr  <= r_addr + ROM_AW'(1);
                    r_state <= LD_LO;
                end
                LD_LO: begin
                    r_hi    <= rom.rom_data;
                    r_state <= LD_END;
                end
                LD_END: begin
                    o_phase_delta[32*int'(r_ch) +: 32] <= {r_hi, rom.rom_data};
                    r_act[r_ch]   <= 1'b1;
                    r_dur[r_ch]   <= r_cur_dur;
                    r_step[r_ch]  <= '0;
                    r_instr[r_ch] <= r_cur_instr;
                    r_state       <= IDLE;
                end
                FR_ADDR: begin
                    r_state <= FR_CAP;
                end
                FR_CAP: begin
                    if (r_act[r_ch]) begin
                        if (r_dur[r_ch] == 5'd0) begin
                            r_act[r_ch]  <= 1'b0;
                            o_envelope[9*int'(r_ch) +: 9] <= '0;
                            o_done[r_ch] <= 1'b1;
                        end else begin
                            o_envelope[9*int'(r_ch) +: 9] <=
                                w_mute[r_ch] ? 9'd0 : rom.rom_data[8:0];
                            r_dur[r_ch] <= r_dur[r_ch] - 5'd1;
                            if (!rom.rom_data[15] &&
                                (r_step[r_ch] != SW'(ENV_LEN - 1)))
                                r_step[r_ch] <= r_step[r_ch] + SW'(1);
                        end
                    end
                    if (w_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_ch    <= w_nx_ch;
                        r_addr  <= env_addr(r_instr[w_nx_ch], r_step[w_nx_ch]);
                        r_state <= FR_ADDR;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_go_ld) begin
                r_state     <= LD_HI;
                r_ch        <= w_ld_ch;
                r_addr      <= pitch_addr(r_sh_pitch[w_ld_ch]);
                r_cur_dur   <= r_sh_dur[w_ld_ch];
                r_cur_instr <= r_sh_instr[w_ld_ch];
            end
        end
    end
endmodule

// File: tb/tb_note_player_mc.sv
// tb_note_player_mc: table vectors, directed corner cases and a random
// run against a frame/load level model of the note player.
`timescale 1ns/1ps
module tb_note_player_mc;
    localparam int N        = 3;
    localparam int ENV_BASE = 128;
    localparam int ENV_LEN  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            frame_stb;
    logic [N-1:0]    load;
    logic [6*N-1:0]  pitch;
    logic [5*N-1:0]  dur;
    logic [4*N-1:0]  instr;
`ifdef NOTE_PLAYER_MC_MUTE_EN
    logic [N-1:0]    mute;
`endif
    logic [32*N-1:0] phase;
    logic [9*N-1:0]  env;
    logic [N-1:0]    done;
    logic            busy;
    logic            overrun;

    note_player_mc_if #(.ROM_AW(8)) bus ();

    note_player_mc #(.NUM_CH(N)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_frame_stb  (frame_stb),
        .i_load       (load),
        .i_pitch      (pitch),
        .i_duration   (dur),
        .i_instrument (instr),
`ifdef NOTE_PLAYER_MC_MUTE_EN
        .i_mute       (mute),
`endif
        .rom          (bus),
        .o_phase_delta(phase),
        .o_envelope   (env),
        .o_done       (done),
        .o_busy       (busy),
        .o_overrun    (overrun)
    );

    logic [15:0] rom [256];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int done_cnt [N];
    int ovr_cnt;
    always @(negedge clk) begin
        for (int c = 0; c < N; c++)
            if (done[c] === 1'b1) done_cnt[c] <= done_cnt[c] + 1;
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    end

    // reference model: voice state advanced per completed load / frame
    logic        m_act   [N];
    int          m_dur   [N];
    int          m_step  [N];
    int          m_instr [N];
    int          m_done  [N];
    logic [31:0] m_phase [N];
    logic [8:0]  m_env   [N];

    int n_pass;
    int n_total;

    task automatic check(input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_act[c] = 1'b0; m_dur[c] = 0; m_step[c] = 0;
            m_instr[c] = 0; m_phase[c] = '0; m_env[c] = '0;
        end
    endtask

    task automatic model_load(input int c, input int p, input int d,
                              input int i);
        m_act[c]   = 1'b1;
        m_dur[c]   = d;
        m_step[c]  = 0;
        m_instr[c] = i;
        m_phase[c] = {rom[(2*p) % 256], rom[(2*p+1) % 256]};
    endtask

    task automatic model_frame();
        logic [15:0] w;
        for (int c = 0; c < N; c++) begin
            if (m_act[c]) begin
                if (m_dur[c] == 0) begin
                    m_act[c] = 1'b0;
                    m_env[c] = '0;
                    m_done[c]++;
                end else begin
                    w = rom[(ENV_BASE + m_instr[c]*ENV_LEN + m_step[c]) % 256];
                    m_env[c] = w[8:0];
                    m_dur[c]--;
                    if (!w[15] && m_step[c] < ENV_LEN - 1) m_step[c]++;
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int c = 0; c < N; c++) begin
            check($sformatf("%s phase%0d", tag, c), 96'(phase[32*c +: 32]),
                  96'(m_phase[c]));
            check($sformatf("%s env%0d", tag, c), 96'(env[9*c +: 9]),
                  96'(m_env[c]));
            check($sformatf("%s done%0d", tag, c), 96'(done_cnt[c]),
                  96'(m_done[c]));
        end
    endtask

    task automatic idle_wait(input string tag);
        int lowc;
        lowc = 0;
        for (int k = 0; k < 300 && lowc < 2; k++) begin
            @(negedge clk);
            lowc = busy ? 0 : lowc + 1;
        end
        check({tag, " idle"}, 96'(lowc >= 2), 96'd1);
    endtask

    task automatic apply_load(input logic [N-1:0] m, input logic [6*N-1:0] p,
                              input logic [5*N-1:0] d, input logic [4*N-1:0] i);
        @(negedge clk);
        load = m; pitch = p; dur = d; instr = i;
        @(negedge clk);
        load = '0;
        idle_wait("load");
        for (int c = 0; c < N; c++)
            if (m[c]) model_load(c, int'(p[6*c +: 6]), int'(d[5*c +: 5]),
                                 int'(i[4*c +: 4]));
    endtask

    task automatic load1(input int c, input int p, input int d, input int i);
        logic [6*N-1:0] pv;
        logic [5*N-1:0] dv;
        logic [4*N-1:0] iv;
        logic [N-1:0]   mv;
        pv = '0; dv = '0; iv = '0; mv = '0;
        pv[6*c +: 6] = 6'(p);
        dv[5*c +: 5] = 5'(d);
        iv[4*c +: 4] = 4'(i);
        mv[c] = 1'b1;
        apply_load(mv, pv, dv, iv);
    endtask

    task automatic do_frame();
        @(negedge clk);
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
        idle_wait("frame");
        model_frame();
    endtask

    typedef struct {
        logic        is_load;
        int          ch;
        int          p;
        int          d;
        int          ins;
        logic [95:0] e_phase;
        logic [26:0] e_env;
        logic [2:0]  e_done;
    } vec_t;

    vec_t tbl [14];

    localparam logic [95:0] P1 = 96'h00000000_1234ABCD_00000000;
    localparam logic [95:0] P2 = 96'h00000000_1234ABCD_00010002;

    initial begin
        int snap [N];
        int bc;
        int ovr0;
        logic [N-1:0]   rm;
        logic [6*N-1:0] rp;
        logic [5*N-1:0] rd;
        logic [4*N-1:0] ri;

        tbl[0]  = '{1'b1, 1, 5, 0, 0, P1, 27'd0,  3'b000};
        tbl[1]  = '{1'b1, 0, 1, 3, 2, P2, 27'd0,  3'b000};
        tbl[2]  = '{1'b0, 0, 0, 0, 0, P2, 27'd10, 3'b010};
        tbl[3]  = '{1'b0, 0, 0, 0, 0, P2, 27'd20, 3'b000};
        tbl[4]  = '{1'b0, 0, 0, 0, 0, P2, 27'd30, 3'b000};
        tbl[5]  = '{1'b0, 0, 0, 0, 0, P2, 27'd0,  3'b001};
        tbl[6]  = '{1'b1, 0, 1, 6, 2, P2, 27'd0,  3'b000};
        tbl[7]  = '{1'b0, 0, 0, 0, 0, P2, 27'd10, 3'b000};
        tbl[8]  = '{1'b0, 0, 0, 0, 0, P2, 27'd20, 3'b000};
        tbl[9]  = '{1'b0, 0, 0, 0, 0, P2, 27'd30, 3'b000};
        tbl[10] = '{1'b0, 0, 0, 0, 0, P2, 27'd30, 3'b000};
        tbl[11] = '{1'b0, 0, 0, 0, 0, P2, 27'd30, 3'b000};
        tbl[12] = '{1'b0, 0, 0, 0, 0, P2, 27'd30, 3'b000};
        tbl[13] = '{1'b0, 0, 0, 0, 0, P2, 27'd0,  3'b001};

        n_pass = 0; n_total = 0;
        for (int c = 0; c < 256; c++) rom[c] = '0;
        rom[2]   = 16'h0001; rom[3]   = 16'h0002;
        rom[10]  = 16'h1234; rom[11]  = 16'hABCD;
        rom[144] = 16'd10;   rom[145] = 16'd20;
        rom[146] = 16'h8000 | 16'd30;
        rom[147] = 16'd40;
        for (int c = 0; c < N; c++) m_done[c] = 0;
        model_reset();

        rst_n = 1'b0; frame_stb = 1'b0; load = '0;
        pitch = '0; dur = '0; instr = '0;
`ifdef NOTE_PLAYER_MC_MUTE_EN
        mute = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst phase", 96'(phase), 96'd0);
        check("rst env", 96'(env), 96'd0);
        check("rst done", 96'(done), 96'd0);
        check("rst busy", 96'(busy), 96'd0);
        check("rst overrun", 96'(overrun), 96'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 14; v++) begin
            for (int c = 0; c < N; c++) snap[c] = done_cnt[c];
            if (tbl[v].is_load) load1(tbl[v].ch, tbl[v].p, tbl[v].d, tbl[v].ins);
            else do_frame();
            check($sformatf("vec%0d phase", v), 96'(phase), tbl[v].e_phase);
            check($sformatf("vec%0d env", v), 96'(env), 96'(tbl[v].e_env));
            for (int c = 0; c < N; c++)
                check($sformatf("vec%0d done%0d", v, c),
                      96'(done_cnt[c] - snap[c]), 96'(tbl[v].e_done[c]));
        end

        // asynchronous reset in the middle of a frame pass
        load1(2, 5, 20, 2);
        do_frame();
        compare_all("pre-rst");
        @(negedge clk); frame_stb = 1'b1;
        @(negedge clk); frame_stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy mid-pass", 96'(busy), 96'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst phase", 96'(phase), 96'd0);
        check("arst env", 96'(env), 96'd0);
        check("arst done", 96'(done), 96'd0);
        check("arst busy", 96'(busy), 96'd0);
        check("arst addr", 96'(bus.rom_addr), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_wait("post-rst");
        compare_all("post-rst");

        // load arriving during a frame pass runs straight after it
        load1(0, 1, 3, 2);
        @(negedge clk); frame_stb = 1'b1;
        @(negedge clk); frame_stb = 1'b0;
        load = 3'b100; pitch = '0; dur = '0; instr = '0;
        pitch[12 +: 6] = 6'd5; dur[10 +: 5] = 5'd4; instr[8 +: 4] = 4'd2;
        bc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            load = '0;
            if (busy) bc++;
            else if (bc > 0) break;
        end
        check("busy span", 96'(bc), 96'(2*N + 3));
        idle_wait("queued");
        model_frame();
        model_load(2, 5, 4, 2);
        compare_all("queued");

        // two frame strobes back to back while a load is running
        ovr0 = ovr_cnt;
        @(negedge clk);
        load = 3'b001; pitch = '0; dur = '0; instr = '0;
        pitch[0 +: 6] = 6'd1; dur[0 +: 5] = 5'd3; instr[0 +: 4] = 4'd2;
        @(negedge clk); load = '0; frame_stb = 1'b1;
        @(negedge clk); frame_stb = 1'b1;
        @(negedge clk); frame_stb = 1'b0;
        idle_wait("overrun");
        model_load(0, 1, 3, 2);
        model_frame();
        check("overrun count", 96'(ovr_cnt - ovr0), 96'd1);
        compare_all("overrun");

`ifdef NOTE_PLAYER_MC_MUTE_EN
        load1(0, 1, 2, 2);
        do_frame();
        compare_all("mute0");
        mute = 3'b001;
        do_frame();
        check("mute env", 96'(env[8:0]), 96'd0);
        m_env[0] = '0;
        do_frame();
        compare_all("mute done");
        mute = '0;
`endif

        // random loads and frames against the model
        for (int c = 0; c < 256; c++) rom[c] = 16'($urandom);
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_frame();
            end else begin
                rm = N'($urandom_range(1, (1 << N) - 1));
                for (int c = 0; c < N; c++) begin
                    rp[6*c +: 6] = 6'($urandom_range(0, 63));
                    rd[5*c +: 5] = 5'($urandom_range(0, 6));
                    ri[4*c +: 4] = 4'($urandom_range(0, 15));
                end
                apply_load(rm, rp, rd, ri);
            end
            compare_all($sformatf("rnd%0d", it));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
